// File: rtl/tx_frame_gen.sv
// tx_frame_gen: upstream test-traffic source for the 16-bit GTX TX path.
// Frames are HEADER, sequence number, PAYLOAD_LEN payload words (PRBS-15 or
// counting pattern) and, when TX_FRAME_GEN_CRC_EN is defined, a CRC-16-CCITT
// trailer. Without the macro the frame ends on the last payload word.
// The FSM state runs one cycle ahead of data_o: every output is a register
// loaded from the word the current state decides to emit.
module tx_frame_gen #(
  parameter int unsigned PAYLOAD_LEN = 62,
  parameter logic [15:0] HEADER_WORD = 16'hA55A,
  parameter logic [15:0] IDLE_WORD   = 16'h0000
) (
  input  logic        gt0_txusrclk2,
  input  logic        gt0_tx_fsm_reset_done,
  input  logic        en_i,
  input  logic        mode_i,
  input  logic        inject_err_i,
  output logic [15:0] data_o,
  output logic        sof_o,
  output logic        eof_o,
  output logic [15:0] seq_o,
  output logic [31:0] frame_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_SEQ,
`ifdef TX_FRAME_GEN_CRC_EN
    S_CRC,
`endif
    S_PAYLOAD
  } state_t;

  localparam logic [9:0]  LAST_IDX = 10'(PAYLOAD_LEN - 1);
  localparam logic [14:0] PRBS_SEED = 15'h7FFF;

  state_t      state, state_n;
  logic [9:0]  idx, idx_n;
  logic        mode_q, mode_n;
  logic [14:0] lfsr, lfsr_n;
  logic        arm, arm_n;
  logic [15:0] data_n;
  logic        sof_n, eof_n;
  logic [15:0] payload_word;
  logic [30:0] prbs_res;
`ifdef TX_FRAME_GEN_CRC_EN
  logic [15:0] crc, crc_n;
`endif

  // Advance the PRBS-15 (x^15+x^14+1) sixteen steps; first generated bit is the MSB.
  // Returns {word, next_lfsr}.
  function automatic logic [30:0] prbs_step(input logic [14:0] s);
    logic [15:0] w;
    logic [14:0] t;
    logic        b;
    w = '0;
    t = s;
    for (int i = 15; i >= 0; i--) begin
      b    = t[14] ^ t[13];
      w[i] = b;
      t    = {t[13:0], b};
    end
    return {w, t};
  endfunction

`ifdef TX_FRAME_GEN_CRC_EN
  // CRC-16-CCITT over one 16-bit word, MSB first, unrolled into one cycle.
  function automatic logic [15:0] crc16_word(input logic [15:0] c_in, input logic [15:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`endif

  // State, payload index, pattern generators and output registers.
  always_ff @(posedge gt0_txusrclk2 or negedge gt0_tx_fsm_reset_done) begin
    if (!gt0_tx_fsm_reset_done) begin
      state  <= S_IDLE;
      idx    <= '0;
      mode_q <= 1'b0;
      lfsr   <= PRBS_SEED;
      arm    <= 1'b0;
      data_o <= IDLE_WORD;
      sof_o  <= 1'b0;
      eof_o  <= 1'b0;
`ifdef TX_FRAME_GEN_CRC_EN
      crc    <= 16'hFFFF;
`endif
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      mode_q <= mode_n;
      lfsr   <= lfsr_n;
      arm    <= arm_n;
      data_o <= data_n;
      sof_o  <= sof_n;
      eof_o  <= eof_n;
`ifdef TX_FRAME_GEN_CRC_EN
      crc    <= crc_n;
`endif
    end
  end

  // Sequence number and frame count step as the last frame word leaves data_o.
  always_ff @(posedge gt0_txusrclk2 or negedge gt0_tx_fsm_reset_done) begin
    if (!gt0_tx_fsm_reset_done) begin
      seq_o       <= '0;
      frame_cnt_o <= '0;
    end else if (eof_o) begin
      seq_o       <= seq_o + 16'd1;
      frame_cnt_o <= frame_cnt_o + 32'd1;
    end
  end

  // Next-state and next-output decode; the error flag is consumed by a payload word.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    mode_n       = mode_q;
    lfsr_n       = lfsr;
    arm_n        = arm | inject_err_i;
    data_n       = IDLE_WORD;
    sof_n        = 1'b0;
    eof_n        = 1'b0;
    prbs_res     = prbs_step(lfsr);
    payload_word = mode_q ? {6'd0, idx} : prbs_res[30:15];
`ifdef TX_FRAME_GEN_CRC_EN
    crc_n        = crc;
`endif
    case (state)
      S_IDLE: begin
        if (en_i) state_n = S_HEAD;
      end
      S_HEAD: begin
        data_n  = HEADER_WORD;
        sof_n   = 1'b1;
        mode_n  = mode_i;
        state_n = S_SEQ;
`ifdef TX_FRAME_GEN_CRC_EN
        crc_n   = 16'hFFFF;
`endif
      end
      S_SEQ: begin
        data_n  = seq_o;
        idx_n   = '0;
        state_n = S_PAYLOAD;
`ifdef TX_FRAME_GEN_CRC_EN
        crc_n   = crc16_word(crc, seq_o);
`endif
      end
      S_PAYLOAD: begin
        if (!mode_q) lfsr_n = prbs_res[14:0];
        if (arm | inject_err_i) begin
          data_n = payload_word ^ 16'h0001;
          arm_n  = 1'b0;
        end else begin
          data_n = payload_word;
        end
        idx_n = idx + 10'd1;
`ifdef TX_FRAME_GEN_CRC_EN
        crc_n = crc16_word(crc, payload_word);
        if (idx == LAST_IDX) state_n = S_CRC;
`else
        if (idx == LAST_IDX) begin
          eof_n   = 1'b1;
          state_n = en_i ? S_HEAD : S_IDLE;
        end
`endif
      end
`ifdef TX_FRAME_GEN_CRC_EN
      S_CRC: begin
        data_n  = crc;
        eof_n   = 1'b1;
        state_n = en_i ? S_HEAD : S_IDLE;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx_frame_gen.sv
// Testbench for tx_frame_gen with PAYLOAD_LEN=4. A reference model pushes the
// expected word stream into a queue; each cycle one entry is popped and checked.
module tb_tx_frame_gen;

  localparam int unsigned P = 4;
  localparam logic [15:0] HDR  = 16'hA55A;
  localparam logic [15:0] IDLE = 16'h0000;
`ifdef TX_FRAME_GEN_CRC_EN
  localparam int FL = P + 3;
`else
  localparam int FL = P + 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        mode = 1'b1;
  logic        inj = 1'b0;
  logic [15:0] data;
  logic        sof, eof;
  logic [15:0] seq;
  logic [31:0] frame_cnt;

  typedef struct {
    logic [15:0] data;
    logic        sof;
    logic        eof;
    logic [15:0] seq;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [15:0] m_seq = '0;
  logic [31:0] m_cnt = '0;
  logic [14:0] m_lfsr = 15'h7FFF;

  tx_frame_gen #(.PAYLOAD_LEN(P), .HEADER_WORD(HDR), .IDLE_WORD(IDLE)) dut (
    .gt0_txusrclk2         (clk),
    .gt0_tx_fsm_reset_done (rst_n),
    .en_i                  (en),
    .mode_i                (mode),
    .inject_err_i          (inj),
    .data_o                (data),
    .sof_o                 (sof),
    .eof_o                 (eof),
    .seq_o                 (seq),
    .frame_cnt_o           (frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_crc(input logic [15:0] c_in, input logic [15:0] w);
    logic [15:0] c;
    c = c_in;
    for (int i = 15; i >= 0; i--) begin
      c = (c[15] ^ w[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic model_prbs(output logic [15:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      b      = m_lfsr[14] ^ m_lfsr[13];
      m_lfsr = {m_lfsr[13:0], b};
      w      = {w[14:0], b};
    end
  endtask

  task automatic push_word(input logic [15:0] d, input logic s, input logic e);
    exp_t x;
    x.data = d; x.sof = s; x.eof = e; x.seq = m_seq; x.cnt = m_cnt;
    exp_q.push_back(x);
    if (e) begin
      m_seq = m_seq + 16'd1;
      m_cnt = m_cnt + 32'd1;
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_word(IDLE, 1'b0, 1'b0);
  endtask

  task automatic push_frame(input logic cnt_mode, input int err_idx);
    logic [15:0] c;
    logic [15:0] w;
    logic [15:0] shown;
    c = 16'hFFFF;
    push_word(HDR, 1'b1, 1'b0);
    c = model_crc(c, m_seq);
    push_word(m_seq, 1'b0, 1'b0);
    for (int k = 0; k < int'(P); k++) begin
      if (cnt_mode) w = 16'(k);
      else          model_prbs(w);
      c = model_crc(c, w);
      shown = (k == err_idx) ? (w ^ 16'h0001) : w;
`ifdef TX_FRAME_GEN_CRC_EN
      push_word(shown, 1'b0, 1'b0);
`else
      push_word(shown, 1'b0, k == int'(P) - 1);
`endif
    end
`ifdef TX_FRAME_GEN_CRC_EN
    push_word(c, 1'b0, 1'b1);
`endif
  endtask

  task automatic apply_stimulus(input logic e, input logic m, input logic i);
    en = e; mode = m; inj = i;
  endtask

  task automatic check_output(input int n);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $error("[TB] FAIL queue_empty: observed data %h expected an entry", data);
      end else begin
        x = exp_q.pop_front();
        compared++;
        assert (data === x.data) else begin mismatched++; $error("[TB] FAIL data: observed %h expected %h", data, x.data); end
        compared++;
        assert (sof === x.sof) else begin mismatched++; $error("[TB] FAIL sof: observed %b expected %b (data %h)", sof, x.sof, x.data); end
        compared++;
        assert (eof === x.eof) else begin mismatched++; $error("[TB] FAIL eof: observed %b expected %b (data %h)", eof, x.eof, x.data); end
        compared++;
        assert (seq === x.seq) else begin mismatched++; $error("[TB] FAIL seq: observed %h expected %h", seq, x.seq); end
        compared++;
        assert (frame_cnt === x.cnt) else begin mismatched++; $error("[TB] FAIL frame_cnt: observed %0d expected %0d", frame_cnt, x.cnt); end
      end
    end
  endtask

  task automatic check_reset(input string tag);
    compared++;
    assert (data === IDLE) else begin mismatched++; $error("[TB] FAIL %s data: observed %h expected %h", tag, data, IDLE); end
    compared++;
    assert (sof === 1'b0 && eof === 1'b0) else begin mismatched++; $error("[TB] FAIL %s sof/eof: observed %b/%b expected 0/0", tag, sof, eof); end
    compared++;
    assert (seq === 16'h0000) else begin mismatched++; $error("[TB] FAIL %s seq: observed %h expected 0000", tag, seq); end
    compared++;
    assert (frame_cnt === 32'd0) else begin mismatched++; $error("[TB] FAIL %s frame_cnt: observed %0d expected 0", tag, frame_cnt); end
  endtask

  initial begin
    // Reset held, then 20 idle cycles.
    apply_stimulus(1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check_reset("in_reset");
    rst_n = 1'b1;
    push_idle(20);
    check_output(20);

    // Counter frame, enable dropped at payload word 1: frame completes, then idle.
    $display("[TB] counter frame with early enable drop");
    apply_stimulus(1'b1, 1'b1, 1'b0);
    push_idle(1);
    push_frame(1'b1, -1);
    push_idle(3);
    check_output(5);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output(FL - 4 + 3);

    // Two back-to-back counter frames.
    $display("[TB] back-to-back counter frames");
    apply_stimulus(1'b1, 1'b1, 1'b0);
    push_idle(1);
    push_frame(1'b1, -1);
    push_frame(1'b1, -1);
    push_idle(2);
    check_output(1 + FL + 4);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output(FL - 4 + 2);

    // Error injected while the header is on the line, then a clean frame.
    $display("[TB] error injection");
    apply_stimulus(1'b1, 1'b1, 1'b0);
    push_idle(1);
    push_frame(1'b1, 0);
    push_frame(1'b1, -1);
    push_idle(2);
    check_output(2);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    check_output(1);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output(FL + 2);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output(FL - 4 + 2);

    // Three PRBS frames; stream continues across frame boundaries from the seed.
    $display("[TB] PRBS frames");
    apply_stimulus(1'b1, 1'b0, 1'b0);
    push_idle(1);
    push_frame(1'b0, -1);
    push_frame(1'b0, -1);
    push_frame(1'b0, -1);
    push_idle(2);
    check_output(1 + 2 * FL + 4);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output(FL - 4 + 2);

    // Reset at payload word 2 of a PRBS frame, then restart from reset values.
    $display("[TB] reset mid-frame");
    apply_stimulus(1'b1, 1'b0, 1'b0);
    push_idle(1);
    push_frame(1'b0, -1);
    check_output(6);
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    exp_q.delete();
    m_seq  = '0;
    m_cnt  = '0;
    m_lfsr = 15'h7FFF;
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(1);
    push_frame(1'b0, -1);
    push_idle(2);
    check_output(5);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output(FL - 4 + 2);

    compared++;
    assert (exp_q.size() == 0) else begin mismatched++; $error("[TB] FAIL queue_drain: observed %0d left expected 0", exp_q.size()); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
